// File: rtl/adc_sample_sequencer.sv
// Paces single-channel ADC conversions at a fixed rate and converts the offset-binary results to signed samples.
// The samples are buffered in a small FIFO and presented on a valid/ready stream.
module adc_sample_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned CHANNEL       = 1,
    parameter int unsigned RSP_TIMEOUT   = 255,
    parameter int unsigned OUT_W         = 16,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clr_status,
    output logic                        cmd_valid,
    output logic [4:0]                  cmd_channel,
    output logic                        cmd_startofpacket,
    output logic                        cmd_endofpacket,
    input  logic                        cmd_ready,
    input  logic                        rsp_valid,
    input  logic [4:0]                  rsp_channel,
    input  logic [11:0]                 rsp_data,
    input  logic                        rsp_startofpacket,
    input  logic                        rsp_endofpacket,
    output logic                        sample_valid,
    output logic [OUT_W-1:0]            sample_data,
    input  logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        missed_tick,
    output logic                        timeout
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int unsigned TO_W   = $clog2(RSP_TIMEOUT + 1);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_ISSUE     = 2'd2,
        S_WAIT_RSP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                tick;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                handshake, rsp_hit, rsp_expire, missed_set;

    logic signed [11:0]  code_s;
    logic [OUT_W-1:0]    conv_sample;
    logic                cap_vld_q;
    logic [OUT_W-1:0]    cap_data_q;

    logic [OUT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                sample_valid_q;
    logic [OUT_W-1:0]    sample_data_q, head_d;
    logic                pop, full, push_ok, overflow_set;

    logic                overflow_q, missed_tick_q, timeout_q;
    logic                unused_rsp_framing;

    assign unused_rsp_framing = rsp_startofpacket ^ rsp_endofpacket;

    assign cmd_channel       = 5'(CHANNEL);
    assign cmd_startofpacket = 1'b1;
    assign cmd_endofpacket   = 1'b1;
    assign cmd_valid         = cmd_valid_q;
    assign sample_valid      = sample_valid_q;
    assign sample_data       = sample_data_q;
    assign fifo_level        = level_q;
    assign overflow          = overflow_q;
    assign missed_tick       = missed_tick_q;
    assign timeout           = timeout_q;

    // Sample-rate counter; parked at zero while disabled so the first tick is a full period away.
    assign tick = (tick_cnt_q == CNT_W'(SAMPLE_PERIOD - 1));

    always_comb begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        if (!enable || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Transaction events decoded from the current state.
    always_comb begin
        handshake  = (state_q == S_ISSUE) && cmd_ready;
        rsp_hit    = (state_q == S_WAIT_RSP) && rsp_valid && (rsp_channel == 5'(CHANNEL));
        rsp_expire = (state_q == S_WAIT_RSP) && !rsp_hit && (to_cnt_q == TO_W'(RSP_TIMEOUT));
        missed_set = tick && ((state_q == S_ISSUE) || (state_q == S_WAIT_RSP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_hit || rsp_expire) begin
                    state_d = enable ? S_WAIT_TICK : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // cmd_valid is registered from the next state so it tracks the ISSUE state exactly.
    always_comb begin
        cmd_valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
        end
    end

    // Response wait counter, restarted by each accepted command and saturating at the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (handshake) begin
            to_cnt_d = '0;
        end else if ((state_q == S_WAIT_RSP) && (to_cnt_q != TO_W'(RSP_TIMEOUT))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Offset binary to two's complement: flip the MSB, then sign-extend.
    assign code_s      = {~rsp_data[11], rsp_data[10:0]};
    assign conv_sample = OUT_W'(code_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q  <= 1'b0;
            cap_data_q <= '0;
        end else begin
            cap_vld_q  <= rsp_hit;
            cap_data_q <= conv_sample;
        end
    end

    // A push into a full FIFO is accepted only when the head is leaving in the same cycle.
    always_comb begin
        pop          = sample_valid_q && sample_ready;
        full         = (level_q == LVL_W'(FIFO_DEPTH));
        push_ok      = cap_vld_q && (!full || pop);
        overflow_set = cap_vld_q && full && !pop;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // The entry being written becomes the head when it lands where the read pointer is going.
        head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? cap_data_q : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cap_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            sample_valid_q <= (level_d != '0);
            sample_data_q  <= head_d;
        end
    end

    // Sticky status; a set event in the same cycle as clr_status keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q    <= 1'b0;
            missed_tick_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            overflow_q    <= (overflow_q    && !clr_status) || overflow_set;
            missed_tick_q <= (missed_tick_q && !clr_status) || missed_set;
            timeout_q     <= (timeout_q     && !clr_status) || rsp_expire;
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: conversion table, command stall, FIFO overflow,
// wrong channel with timeout, sticky clear, enable drop and reset in the middle of a request.
module tb_adc_sample_sequencer;

    localparam int unsigned SP = 16;
    localparam int unsigned TO = 255;
    localparam int unsigned OW = 16;
    localparam int unsigned FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clr_status;
    logic          cmd_valid;
    logic [4:0]    cmd_channel;
    logic          cmd_startofpacket;
    logic          cmd_endofpacket;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [4:0]    rsp_channel;
    logic [11:0]   rsp_data;
    logic          rsp_startofpacket;
    logic          rsp_endofpacket;
    logic          sample_valid;
    logic [OW-1:0] sample_data;
    logic          sample_ready;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic          missed_tick;
    logic          timeout;

    adc_sample_sequencer #(
        .SAMPLE_PERIOD(SP),
        .CHANNEL      (1),
        .RSP_TIMEOUT  (TO),
        .OUT_W        (OW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .clr_status       (clr_status),
        .cmd_valid        (cmd_valid),
        .cmd_channel      (cmd_channel),
        .cmd_startofpacket(cmd_startofpacket),
        .cmd_endofpacket  (cmd_endofpacket),
        .cmd_ready        (cmd_ready),
        .rsp_valid        (rsp_valid),
        .rsp_channel      (rsp_channel),
        .rsp_data         (rsp_data),
        .rsp_startofpacket(rsp_startofpacket),
        .rsp_endofpacket  (rsp_endofpacket),
        .sample_valid     (sample_valid),
        .sample_data      (sample_data),
        .sample_ready     (sample_ready),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .missed_tick      (missed_tick),
        .timeout          (timeout)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int hs_cnt = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    int issue_cyc;
    int hs_cyc;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    typedef struct {
        logic [11:0] code;
        int          exp_sample;
    } conv_vec_t;

    conv_vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        n_cmp++;
        if (cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_wait: cmd_valid=%b, expected 1 within 60 cycles", cmd_valid);
        end
    endtask

    // Waits for a command, accepts it (cmd_ready is assumed high) and optionally answers after lat cycles.
    task automatic do_request(input logic [11:0] code, input logic [4:0] chan, input int lat,
                              input bit give_rsp, input bit drop_en);
        wait_cmd();
        issue_cyc = cyc;
        step();
        hs_cyc = cyc;
        if (drop_en) enable = 1'b0;
        if (give_rsp) begin
            repeat (lat - 1) step();
            rsp_valid   = 1'b1;
            rsp_channel = chan;
            rsp_data    = code;
            step();
            rsp_valid   = 1'b0;
            rsp_channel = 5'd0;
            rsp_data    = 12'd0;
        end
    endtask

    task automatic pop_one();
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary by cycle %0d", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        int prev_issue;
        int hs0;
        int elapsed;
        int n;

        vecs[0] = '{12'h000, -2048};
        vecs[1] = '{12'h800, 0};
        vecs[2] = '{12'hFFF, 2047};
        vecs[3] = '{12'h7FF, -1};
        vecs[4] = '{12'h801, 1};
        vecs[5] = '{12'h400, -1024};

        rst = 1'b1; enable = 1'b0; clr_status = 1'b0; cmd_ready = 1'b1;
        rsp_valid = 1'b0; rsp_channel = 5'd0; rsp_data = 12'd0;
        rsp_startofpacket = 1'b1; rsp_endofpacket = 1'b1; sample_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state and tied command fields
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_sample_valid", 32'(sample_valid), 0);
        chk("rst_fifo_level", 32'(fifo_level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_missed_tick", 32'(missed_tick), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("cmd_channel", 32'(cmd_channel), 1);
        chk("cmd_sop", 32'(cmd_startofpacket), 1);
        chk("cmd_eop", 32'(cmd_endofpacket), 1);

        // Conversion table: one request per period, 3-cycle response latency
        enable = 1'b1;
        prev_issue = 0;
        for (int i = 0; i < 6; i++) begin
            do_request(vecs[i].code, 5'd1, 3, 1'b1, 1'b0);
            chk("lat_not_yet_valid", 32'(sample_valid), 0);
            step();
            chk("lat_valid", 32'(sample_valid), 1);
            chk("conv_sample", 32'($signed(sample_data)), vecs[i].exp_sample);
            if (i > 0) chk("cmd_period", issue_cyc - prev_issue, SP);
            prev_issue = issue_cyc;
            pop_one();
            chk("pop_empty", 32'(sample_valid), 0);
        end
        chk("table_overflow", 32'(overflow), 0);
        chk("table_missed", 32'(missed_tick), 0);
        chk("table_timeout", 32'(timeout), 0);

        // Command held for 5 cycles by cmd_ready=0
        cmd_ready = 1'b0;
        wait_cmd();
        hs0 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            chk("stall_cmd_valid", 32'(cmd_valid), 1);
            chk("stall_cmd_channel", 32'(cmd_channel), 1);
            step();
        end
        cmd_ready = 1'b1;
        step();
        chk("stall_cmd_dropped", 32'(cmd_valid), 0);
        step();
        rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'h900;
        step();
        rsp_valid = 1'b0;
        step();
        chk("stall_handshakes", hs_cnt - hs0, 1);
        chk("stall_sample", 32'($signed(sample_data)), 256);
        pop_one();

        // Ten responses with no consumer: the last two are dropped
        for (int k = 1; k <= 10; k++) begin
            do_request(12'(12'h800 + k), 5'd1, 3, 1'b1, 1'b0);
            step();
            step();
            if (k == 8) begin
                chk("fill_level8", 32'(fifo_level), 8);
                chk("fill_no_overflow", 32'(overflow), 0);
            end
            if (k == 9) begin
                chk("ovf_level", 32'(fifo_level), 8);
                chk("ovf_flag", 32'(overflow), 1);
            end
        end
        chk("ovf_level_after10", 32'(fifo_level), 8);
        enable = 1'b0;
        step();
        step();
        sample_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            chk("drain_valid", 32'(sample_valid), 1);
            chk("drain_order", 32'($signed(sample_data)), j);
            step();
        end
        sample_ready = 1'b0;
        chk("drain_empty", 32'(sample_valid), 0);
        chk("drain_level", 32'(fifo_level), 0);
        chk("drain_missed", 32'(missed_tick), 0);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Wrong-channel response is ignored, request times out, then a fresh command follows
        enable = 1'b1;
        do_request(12'h123, 5'd3, 3, 1'b1, 1'b0);
        step();
        step();
        chk("wrongch_level", 32'(fifo_level), 0);
        chk("wrongch_valid", 32'(sample_valid), 0);
        n = 0;
        while (timeout !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        elapsed = cyc - hs_cyc;
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_window", 32'(elapsed >= 250 && elapsed <= 260), 1);
        chk("missed_set", 32'(missed_tick), 1);
        chk("timeout_no_sample", 32'(fifo_level), 0);
        do_request(12'hFFF, 5'd1, 3, 1'b1, 1'b0);
        step();
        chk("after_timeout_valid", 32'(sample_valid), 1);
        chk("after_timeout_sample", 32'($signed(sample_data)), 2047);
        pop_one();

        // Clear pulse drops every sticky flag
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_missed", 32'(missed_tick), 0);
        chk("clr_timeout", 32'(timeout), 0);

        // Enable dropped during WAIT_RSP: request completes, no new command
        do_request(12'h000, 5'd1, 3, 1'b1, 1'b1);
        step();
        chk("dis_sample_valid", 32'(sample_valid), 1);
        chk("dis_sample", 32'($signed(sample_data)), -2048);
        pop_one();
        hs0 = hs_cnt;
        repeat (40) step();
        chk("dis_no_new_cmd", hs_cnt - hs0, 0);
        chk("dis_cmd_valid", 32'(cmd_valid), 0);

        // Reset while waiting for a response; the late response must be ignored
        enable = 1'b1;
        do_request(12'h000, 5'd1, 3, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_cmd_valid", 32'(cmd_valid), 0);
        step();
        rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'hABC;
        step();
        rsp_valid = 1'b0;
        step();
        step();
        chk("midrst_sample_valid", 32'(sample_valid), 0);
        chk("midrst_level", 32'(fifo_level), 0);
        chk("midrst_cmd_valid_late", 32'(cmd_valid), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_missed", 32'(missed_tick), 0);
        chk("midrst_timeout", 32'(timeout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Sits between the on-chip modular ADC subsystem and the CNN input pipeline.
- Issues single-channel conversion commands at a fixed sample rate on the ADC Avalon-ST command interface.
- Captures each response and converts the 12-bit offset-binary code to a signed two's-complement sample.
- Buffers samples in a small FIFO and presents them on a valid/ready stream to the CNN front end.

Parameters:
- SAMPLE_PERIOD, 1000: clk cycles between conversion requests (min 16).
- CHANNEL, 1: ADC channel number driven on cmd_channel.
- RSP_TIMEOUT, 255: clk cycles to wait for a response before abandoning it.
- OUT_W, 16: sample output width (>= 12).
- FIFO_DEPTH, 8: sample FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock; the ADC command and response interfaces are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = run sampling; 0 = finish any outstanding request, then stop.
- clr_status  in  1  one-cycle pulse; clears all sticky flags.
- cmd_valid  out  1  command valid to the ADC.
- cmd_channel  out  5  = CHANNEL.
- cmd_startofpacket  out  1  tied 1.
- cmd_endofpacket  out  1  tied 1.
- cmd_ready  in  1  ADC accepts the command.
- rsp_valid  in  1  ADC response valid (no backpressure).
- rsp_channel  in  5  response channel.
- rsp_data  in  12  offset-binary conversion result.
- rsp_startofpacket  in  1  ignored.
- rsp_endofpacket  in  1  ignored.
- sample_valid  out  1  FIFO not empty.
- sample_data  out  OUT_W  signed sample at the FIFO head.
- sample_ready  in  1  consumer accepts the head sample.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- missed_tick  out  1  sticky: a sample tick arrived while a request was still outstanding.
- timeout  out  1  sticky: a response did not arrive within RSP_TIMEOUT cycles.

Behaviour:
- Reset values: cmd_valid=0, sample_valid=0, fifo_level=0, all sticky flags=0, state=IDLE, tick counter=0, FIFO empty.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1.
  - Held at 0 while enable=0.
  - tick=1 in the cycle the count equals SAMPLE_PERIOD-1.
- FSM states are IDLE, WAIT_TICK, ISSUE, WAIT_RSP.
  - IDLE: go to WAIT_TICK when enable=1.
  - WAIT_TICK: on tick go to ISSUE; if enable=0 go to IDLE.
  - ISSUE: cmd_valid=1, held stable until cmd_ready=1 is sampled; the handshake cycle moves to WAIT_RSP and clears the timeout counter.
  - WAIT_RSP: rsp_valid=1 with rsp_channel==CHANNEL captures the sample and goes to WAIT_TICK (or IDLE if enable=0). Responses with any other channel are ignored.
  - WAIT_RSP: if the timeout counter reaches RSP_TIMEOUT, set timeout and go to WAIT_TICK (or IDLE if enable=0).
- Missed ticks: a tick occurring in ISSUE or WAIT_RSP sets missed_tick. The request in flight continues and the tick is not queued.
- enable deassertion: dropping enable in ISSUE or WAIT_RSP does not abort the request; return to IDLE happens after completion or timeout.
- Conversion: sample = {~rsp_data[11], rsp_data[10:0]} sign-extended to OUT_W. Examples: 0x000 -> -2048, 0x800 -> 0, 0xFFF -> +2047.
- Capture-to-output latency: the sample is written to the FIFO the cycle after the response. With an empty FIFO, sample_valid rises 2 cycles after the rsp_valid cycle.
- FIFO:
  - sample_data is registered from the head entry and stable while sample_valid=1 and sample_ready=0.
  - A pop occurs when sample_valid && sample_ready.
  - Write while full: the sample is dropped and overflow is set. A write and a pop in the same cycle while full is not an overflow; the write is accepted.
  - Simultaneous write and pop: fifo_level is unchanged.
- Sticky flags: set events win over clr_status in the same cycle.
- Reset mid-request: all state returns to reset values, cmd_valid drops in the next cycle, and any late response is ignored because the state is IDLE.

Test Plan:
- SAMPLE_PERIOD=16, enable=1, cmd_ready tied 1, responses of 0x000, 0x800, 0xFFF with 3-cycle latency -> one command every 16 cycles; samples out = -2048, 0, 2047; no flags set.
- cmd_ready held low for 5 cycles in ISSUE -> cmd_valid stays 1 with cmd_channel=1 throughout; exactly one command is accepted.
- sample_ready=0 with FIFO_DEPTH=8 and 10 responses -> fifo_level=8 and overflow=1; draining yields the first 8 samples in order.
- Response with rsp_channel=3, then no response -> sample is ignored, timeout=1 after 255 cycles, FSM back in WAIT_TICK, next tick issues a new command.
- RSP_TIMEOUT=255 > SAMPLE_PERIOD=16 with response withheld -> missed_tick=1; clr_status pulse then clears all flags.
- rst asserted while in WAIT_RSP, response arrives 2 cycles later -> no sample written; all outputs at reset values.
